// File: rtl/gate_truth_table_seq.sv
// gate_truth_table_seq
// Stimulus sequencer and response capture for a 2-input gate under test.
// On start it steps {in1,in2} through 00,01,10,11, holding each combination
// for HOLD_CYCLES clocks. It samples the gate output at the last edge of each
// hold window into table_out[{in1,in2}].
// Optional feature macro: EXPECT_CHECK_EN. When defined, the module adds the
// 'expected' input and the 'mismatch' output, and compares the captured table
// against the expected value at the end of the sweep.
module gate_truth_table_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out,
`ifdef EXPECT_CHECK_EN
    input  logic [3:0] expected,
    output logic       mismatch,
`endif
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [3:0] table_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       idx;
    logic [1:0]       idx_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             in1_nxt;
    logic             in2_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             valid_nxt;
    logic [3:0]       table_nxt;
    logic             hold_end;
`ifdef EXPECT_CHECK_EN
    logic [3:0]       expected_r;
    logic [3:0]       expected_nxt;
    logic             mismatch_nxt;
`endif

    // The last edge of the current hold window: the edge where the gate output is sampled
    assign hold_end = (state == DRIVE) && (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> DRIVE on start, DRIVE -> DONE after combination 3, DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DRIVE: begin
                if (hold_end && (idx == 2'd3)) begin
                    state_nxt = DONE_ST;
                end else begin
                    state_nxt = DRIVE;
                end
            end
            DONE_ST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath logic: next values of all registered outputs and counters
    always_comb begin
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        in1_nxt   = 1'b0;
        in2_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        valid_nxt = valid;
        table_nxt = table_out;
`ifdef EXPECT_CHECK_EN
        expected_nxt = expected_r;
        mismatch_nxt = mismatch;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                    table_nxt = 4'b0000;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef EXPECT_CHECK_EN
                    expected_nxt = expected;
                    mismatch_nxt = 1'b0;
`endif
                end else begin
                    busy_nxt = 1'b0;
                end
            end
            DRIVE: begin
                busy_nxt = 1'b1;
                if (hold_end) begin
                    table_nxt[idx] = out;
                    if (idx == 2'd3) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        valid_nxt = 1'b1;
`ifdef EXPECT_CHECK_EN
                        mismatch_nxt = (table_nxt != expected_r);
`endif
                    end else begin
                        idx_nxt              = idx + 2'd1;
                        cnt_nxt              = '0;
                        {in1_nxt, in2_nxt}   = idx + 2'd1;
                    end
                end else begin
                    cnt_nxt            = cnt + CNT_W'(1);
                    {in1_nxt, in2_nxt} = idx;
                end
            end
            DONE_ST: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; every output is driven from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd0;
            cnt       <= '0;
            in1       <= 1'b0;
            in2       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            table_out <= 4'b0000;
`ifdef EXPECT_CHECK_EN
            expected_r <= 4'b0000;
            mismatch   <= 1'b0;
`endif
        end else begin
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            in1       <= in1_nxt;
            in2       <= in2_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            valid     <= valid_nxt;
            table_out <= table_nxt;
`ifdef EXPECT_CHECK_EN
            expected_r <= expected_nxt;
            mismatch   <= mismatch_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gate_truth_table_seq.sv
// Testbench for gate_truth_table_seq. It uses two instances: one with
// HOLD_CYCLES=4 driving an OR/AND/XOR model, and one with HOLD_CYCLES=2
// driving an XOR model. Expected tables are queued at start and compared
// when done rises.
`timescale 1ns/1ps
module tb_gate_truth_table_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] gate_a = 2'd0;
    logic       out_a, out_b;
    logic       in1_a, in2_a, busy_a, done_a, valid_a;
    logic       in1_b, in2_b, busy_b, done_b, valid_b;
    logic [3:0] table_a, table_b;
`ifdef EXPECT_CHECK_EN
    logic [3:0] expected_a = 4'b0000;
    logic [3:0] expected_b = 4'b0000;
    logic       mismatch_a, mismatch_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] sb_a[$];
    logic [3:0] sb_b[$];

    always #5 clk = ~clk;

    // Gate models: 0=OR, 1=AND, 2=XOR
    assign out_a = (gate_a == 2'd0) ? (in1_a | in2_a) :
                   (gate_a == 2'd1) ? (in1_a & in2_a) : (in1_a ^ in2_a);
    assign out_b = in1_b ^ in2_b;

    gate_truth_table_seq #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .out(out_a),
`ifdef EXPECT_CHECK_EN
        .expected(expected_a), .mismatch(mismatch_a),
`endif
        .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a),
        .valid(valid_a), .table_out(table_a)
    );

    gate_truth_table_seq #(.HOLD_CYCLES(2), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .out(out_b),
`ifdef EXPECT_CHECK_EN
        .expected(expected_b), .mismatch(mismatch_b),
`endif
        .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b),
        .valid(valid_b), .table_out(table_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called on the negedge right after the edge that accepted start on DUT A.
    // Follows the sweep cycle by cycle until done, then pops the expected table.
    task automatic wait_sweep_a();
        int c = 0;
        while (!done_a && c < 64) begin
            check("a_busy", busy_a, 1);
            check("a_inputs", {in1_a, in2_a}, c / 4);
            c++;
            @(negedge clk);
        end
        check("a_done_latency", c, 16);
        check("a_done", done_a, 1);
        check("a_busy_at_done", busy_a, 0);
        check("a_valid", valid_a, 1);
        check("a_inputs_at_done", {in1_a, in2_a}, 0);
        check("a_sb_size", sb_a.size(), 1);
        if (sb_a.size() > 0) check("a_table", table_a, sb_a.pop_front());
    endtask

    task automatic wait_sweep_b();
        int c = 0;
        while (!done_b && c < 64) begin
            check("b_busy", busy_b, 1);
            check("b_inputs", {in1_b, in2_b}, c / 2);
            c++;
            @(negedge clk);
        end
        check("b_done_latency", c, 8);
        check("b_done", done_b, 1);
        check("b_valid", valid_b, 1);
        check("b_sb_size", sb_b.size(), 1);
        if (sb_b.size() > 0) check("b_table", table_b, sb_b.pop_front());
    endtask

    // Single-pulse sweep on DUT A, followed by the checks on the done pulse and held result
    task automatic sweep_a(input logic [1:0] gate, input logic [3:0] exp_table);
        gate_a = gate;
        @(negedge clk);
        start_a = 1'b1;
        sb_a.push_back(exp_table);
        @(negedge clk);
        start_a = 1'b0;
        wait_sweep_a();
        @(negedge clk);
        check("a_done_pulse_width", done_a, 0);
        check("a_valid_held", valid_a, 1);
        check("a_table_held", table_a, exp_table);
        check("a_idle_busy", busy_a, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs_a", {in1_a, in2_a, busy_a, done_a, valid_a, table_a}, 0);
        check("rst_outputs_b", {in1_b, in2_b, busy_b, done_b, valid_b, table_b}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs_a", {busy_a, done_a, valid_a, table_a}, 0);

        // OR, then AND
        sweep_a(2'd0, 4'b1110);
        sweep_a(2'd1, 4'b1000);

        // start held high on OR: two back-to-back sweeps
        gate_a = 2'd0;
        @(negedge clk);
        start_a = 1'b1;
        sb_a.push_back(4'b1110);
        @(negedge clk);
        wait_sweep_a();
        @(negedge clk);
        check("b2b_idle_busy", busy_a, 0);
        check("b2b_idle_done", done_a, 0);
        sb_a.push_back(4'b1110);
        @(negedge clk);
        wait_sweep_a();
        start_a = 1'b0;
        @(negedge clk);
        check("b2b_end_busy", busy_a, 0);
        @(negedge clk);
        check("b2b_no_third", busy_a, 0);

        // Async reset mid-sweep at idx=2, then a clean AND sweep
        gate_a = 2'd0;
        @(negedge clk);
        start_a = 1'b1;
        sb_a.push_back(4'b1110);
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_inputs", {in1_a, in2_a}, 2);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", {in1_a, in2_a, busy_a, done_a, valid_a, table_a}, 0);
        sb_a.delete();
        @(negedge clk);
        rst = 1'b0;
        sweep_a(2'd1, 4'b1000);

        // HOLD_CYCLES=2, XOR
        @(negedge clk);
        start_b = 1'b1;
        sb_b.push_back(4'b0110);
        @(negedge clk);
        start_b = 1'b0;
        wait_sweep_b();
        @(negedge clk);
        check("b_done_pulse_width", done_b, 0);

`ifdef EXPECT_CHECK_EN
        expected_a = 4'b1000;
        sweep_a(2'd0, 4'b1110);
        check("mismatch_set", mismatch_a, 1);
        expected_a = 4'b1110;
        sweep_a(2'd0, 4'b1110);
        check("mismatch_clear", mismatch_a, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
